// File: rtl/seq_uart_tx.sv
// seq_uart_tx: samples the selected sequence value on each rising edge of the
// divider output and queues it in a small FIFO. Each queued byte is sent as an
// 8N1 UART frame on tx (start bit, 8 data bits LSB first, stop bit).
// Consecutive frames are separated by exactly one idle clock.
module seq_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_tick,
  input  logic                          enable,
  input  logic                          clear,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_COUNT = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Tick edge detection
  // ---------------------------------------------------------------------------
  logic tick_q;
  logic tick_qq;
  logic capture;

  // Two-stage history of the divider level; a 0->1 step marks a new sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= 1'b0;
      tick_qq <= 1'b0;
    end else begin
      tick_q  <= sample_tick;
      tick_qq <= tick_q;
    end
  end

  // The sequence registers move on the tick edge itself, so one clock later
  // sample_in has settled and is safe to capture.
  assign capture = tick_q & ~tick_qq & enable;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  tx_state_e     state_q, state_d;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  // Full/empty are judged on the pre-edge count: a sample arriving while full
  // is dropped even if a pop frees a slot on the same edge, and a sample
  // pushed into an empty FIFO is only visible to the transmitter next cycle.
  // clear wins over both push and pop.
  assign push = capture & ~fifo_full & ~clear;
  assign pop  = (state_q == ST_IDLE) & ~fifo_empty & ~clear;

  // Next-state for pointers, occupancy count and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = PW'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      end
      case ({push, pop})
        2'b10:   count_d = LW'(count_q + 1'b1);
        2'b01:   count_d = LW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
      if (capture && fifo_full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tx_q, tx_d;

  // Frame sequencing; tx is registered so the line never glitches.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    tx_d       = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d    = ST_START;
          shift_d    = fifo_head;
          bit_idx_d  = 3'd0;
          baud_cnt_d = 16'd0;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 16'd0;
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = 3'(bit_idx_q + 1'b1);
            tx_d      = shift_q[bit_idx_d];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = 16'd0;
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Transmitter FSM registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);
  assign fifo_level = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// Bench for seq_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4. Inputs are
// driven on the falling edge, outputs sampled on the falling edge.
module tb_seq_uart_tx;

  localparam int CPB = 4;
  localparam int FD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_tick = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seq_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_tick(sample_tick),
    .enable     (enable),
    .clear      (clear),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then checks all 10 bits cycle by cycle.
  // Returns the number of idle cycles seen before the start bit.
  task automatic expect_frame(input string tag, input logic [7:0] b,
                              output int waited, output logic busy_seen);
    logic [9:0] bits;
    logic [3:0] samp;
    logic       found;
    logic       busy_all;
    bits      = {1'b1, b, 1'b0};
    waited    = 0;
    busy_seen = 1'b0;
    found     = 1'b0;
    busy_all  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        found = 1'b1;
        break;
      end
      waited++;
      busy_seen = busy_seen | busy;
    end
    check({tag, "_start"}, 32'(found), 1);
    if (found) begin
      for (int k = 0; k < 10; k++) begin
        samp = 4'd0;
        for (int c = 0; c < CPB; c++) begin
          if (!(k == 0 && c == 0)) @(negedge clk);
          samp[c]  = tx;
          busy_all = busy_all & busy;
        end
        check($sformatf("%s_bit%0d", tag, k), 32'(samp), bits[k] ? 32'hF : 32'h0);
      end
      check({tag, "_busy"}, 32'(busy_all), 1);
    end
  endtask

  // Watches for n cycles and returns how many had tx low / busy high.
  task automatic watch_quiet(input int n, output int low_cnt, output int busy_cnt);
    low_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx == 1'b0) low_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         w;
    logic       bs;
    int         lows;
    int         busys;
    logic [2:0] max_lvl;
    logic       min_tx;
    logic       ovf_seen;

    // 1. Reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_in   = 8'($urandom_range(0, 255));
      sample_tick = 1'($urandom_range(0, 1));
      enable      = 1'($urandom_range(0, 1));
      clear       = 1'($urandom_range(0, 1));
      #1;
      check("rst_outputs", 32'({tx, busy, fifo_level, overflow}), 32'b10_0000);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    clear       = 1'b0;
    enable      = 1'b1;
    sample_in   = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 32'(tx), 1);
    check("post_rst_lvl", 32'(fifo_level), 0);

    // 2. Single frame 0x55
    @(negedge clk);
    sample_in   = 8'h55;
    sample_tick = 1'b1;
    @(negedge clk);
    check("t2_lvl_e0", 32'(fifo_level), 0);
    sample_tick = 1'b0;
    @(negedge clk);
    check("t2_lvl_push", 32'(fifo_level), 1);
    check("t2_tx_before", 32'(tx), 1);
    check("t2_busy_before", 32'(busy), 0);
    expect_frame("t2", 8'h55, w, bs);
    check("t2_latency", 32'(w), 0);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 0);
    check("t2_tx_after", 32'(tx), 1);
    check("t2_lvl_after", 32'(fifo_level), 0);

    // 3. Overflow: six ticks every 2 clocks
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (k == 5) begin
            check("t3_lvl_full", 32'(fifo_level), 4);
            check("t3_ovf_pre", 32'(overflow), 0);
          end
          sample_tick = 1'b1;
          sample_in   = 8'(k + 1);
          @(negedge clk);
          sample_tick = 1'b0;
        end
        @(negedge clk);
        check("t3_lvl_drop", 32'(fifo_level), 4);
        check("t3_ovf_set", 32'(overflow), 1);
      end
      begin
        int   fw;
        logic fbs;
        logic [7:0] eb;
        for (int f = 0; f < 5; f++) begin
          eb = exp_q.pop_front();
          expect_frame($sformatf("t3_f%0d", f), eb, fw, fbs);
          if (f > 0) begin
            check($sformatf("t3_gap%0d", f), 32'(fw), 1);
            check($sformatf("t3_gapbusy%0d", f), 32'(fbs), 0);
          end
        end
      end
    join
    watch_quiet(50, lows, busys);
    check("t3_no_sixth", 32'(lows), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    check("t3_lvl_end", 32'(fifo_level), 0);

    // 4. Clear with a simultaneous capture during a frame
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          sample_tick = 1'b1;
          sample_in   = 8'(8'hA1 + k);
          @(negedge clk);
          sample_tick = 1'b0;
        end
        @(negedge clk);
        check("t4_lvl_full", 32'(fifo_level), 4);
        check("t4_ovf_pre", 32'(overflow), 1);
        sample_tick = 1'b1;
        sample_in   = 8'hA6;
        @(negedge clk);
        sample_tick = 1'b0;
        clear       = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t4_lvl_clr", 32'(fifo_level), 0);
        check("t4_ovf_clr", 32'(overflow), 0);
      end
      begin
        int   fw;
        logic fbs;
        int   lc;
        int   bc;
        expect_frame("t4", 8'hA1, fw, fbs);
        watch_quiet(60, lc, bc);
        check("t4_no_more_frames", 32'(lc), 0);
        check("t4_no_more_busy", 32'(bc), 0);
      end
    join
    check("t4_lvl_end", 32'(fifo_level), 0);
    check("t4_ovf_end", 32'(overflow), 0);

    // 5. enable low: ticks ignored
    enable   = 1'b0;
    max_lvl  = 3'd0;
    min_tx   = 1'b1;
    ovf_seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      sample_tick = (k < 10) ? 1'b1 : 1'b0;
      sample_in   = 8'(8'h30 + k);
      @(negedge clk);
      sample_tick = 1'b0;
      if (fifo_level > max_lvl) max_lvl = fifo_level;
      min_tx   = min_tx & tx;
      ovf_seen = ovf_seen | overflow;
    end
    check("t5_lvl", 32'(max_lvl), 0);
    check("t5_tx", 32'(min_tx), 1);
    check("t5_ovf", 32'(ovf_seen), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // 6. Async reset during data bit 3
    @(negedge clk);
    sample_tick = 1'b1;
    sample_in   = 8'h55;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    sample_in   = 8'h77;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (17) @(negedge clk);
    check("t6_bit3_tx", 32'(tx), 0);
    check("t6_bit3_busy", 32'(busy), 1);
    check("t6_bit3_lvl", 32'(fifo_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_tx", 32'(tx), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_lvl", 32'(fifo_level), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(60, lows, busys);
    check("t6_no_frame", 32'(lows), 0);
    check("t6_no_busy", 32'(busys), 0);
    check("t6_lvl_end", 32'(fifo_level), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
